// File: rtl/hazard_stall_ctrl.sv
// Stall/flush interlock for the 5-stage core: load-use bubble, mult/div freeze, taken-branch squash.
// Optional HAZARD_STALL_STATS_EN adds saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          inst_out_fd,
  input  logic [31:0]          DX_inst,
  input  logic                 branch_taken,
  input  logic                 multdiv_ready,
  output logic                 pc_en,
  output logic                 fd_en,
  output logic                 dx_en,
  output logic                 fd_flush,
  output logic                 dx_nop,
  output logic                 xm_nop,
  output logic                 ctrl_MULT,
  output logic                 ctrl_DIV,
  output logic                 md_busy,
  output logic                 md_timeout
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          flush_count
`endif
);

  localparam logic [4:0] OpAlu  = 5'b00000;
  localparam logic [4:0] OpAddi = 5'b00101;
  localparam logic [4:0] OpLw   = 5'b01000;
  localparam logic [4:0] OpSw   = 5'b00111;
  localparam logic [4:0] OpBne  = 5'b00010;
  localparam logic [4:0] OpBlt  = 5'b00110;
  localparam logic [4:0] OpJr   = 5'b00100;
  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMdWait} stateE;

  stateE            stateQ;
  logic [CNT_W-1:0] mdCntQ;
  logic             timeoutQ;

  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic [4:0] dxOp, dxRd, dxAluOp;
  logic       useRs, useRt, useRd, loadUse;
  logic       dxIsMult, dxIsDiv, mdStart, timeoutHit, mdRelease;
  logic       unusedBits;

  assign fdOp    = inst_out_fd[31:27];
  assign fdRd    = inst_out_fd[26:22];
  assign fdRs    = inst_out_fd[21:17];
  assign fdRt    = inst_out_fd[16:12];
  assign dxOp    = DX_inst[31:27];
  assign dxRd    = DX_inst[26:22];
  assign dxAluOp = DX_inst[6:2];
  assign unusedBits = ^{inst_out_fd[11:0], DX_inst[21:7], DX_inst[1:0]};

  // sw only reads rd as store data, which the memory-data bypass covers, so rd use excludes sw.
  assign useRs   = (fdOp == OpAlu) || (fdOp == OpAddi) || (fdOp == OpLw) || (fdOp == OpSw);
  assign useRt   = (fdOp == OpAlu);
  assign useRd   = (fdOp == OpBne) || (fdOp == OpBlt) || (fdOp == OpJr);
  assign loadUse = (dxOp == OpLw) && (dxRd != 5'd0) &&
                   ((useRs && (fdRs == dxRd)) || (useRt && (fdRt == dxRd)) ||
                    (useRd && (fdRd == dxRd)));

  assign dxIsMult   = (dxOp == OpAlu) && (dxAluOp == AluMul);
  assign dxIsDiv    = (dxOp == OpAlu) && (dxAluOp == AluDiv);
  assign mdStart    = (stateQ == StRun) && (dxIsMult || dxIsDiv);
  assign timeoutHit = (stateQ == StMdWait) && (mdCntQ == TimeoutLast);
  assign mdRelease  = (stateQ == StMdWait) && (multdiv_ready || timeoutHit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ   <= StRun;
      mdCntQ   <= '0;
      timeoutQ <= 1'b0;
    end else begin
      unique case (stateQ)
        StRun: begin
          if (mdStart) begin
            stateQ <= StMdWait;
            mdCntQ <= '0;
          end
        end
        StMdWait: begin
          if (mdRelease) begin
            stateQ <= StRun;
            if (!multdiv_ready) timeoutQ <= 1'b1;
          end else begin
            mdCntQ <= mdCntQ + 1'b1;
          end
        end
        default: stateQ <= StRun;
      endcase
    end
  end

  // Gated by reset so the reset values appear immediately, whatever the latches hold.
  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    dx_en      = 1'b1;
    fd_flush   = 1'b0;
    dx_nop     = 1'b0;
    xm_nop     = 1'b0;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    md_busy    = 1'b0;
    md_timeout = timeoutQ;
    if (!reset) begin
      if (stateQ == StRun) begin
        if (mdStart) begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_nop    = 1'b1;
          ctrl_MULT = dxIsMult;
          ctrl_DIV  = dxIsDiv;
        end else if (branch_taken) begin
          fd_flush = 1'b1;
          dx_nop   = 1'b1;
        end else if (loadUse) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_nop = 1'b1;
        end
      end else if (!mdRelease) begin
        md_busy = 1'b1;
        pc_en   = 1'b0;
        fd_en   = 1'b0;
        dx_en   = 1'b0;
        xm_nop  = 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (fd_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch flush, mult/div freeze, watchdog, reset.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_out_fd, DX_inst;
  logic        branch_taken, multdiv_ready;
  logic        pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop;
  logic        ctrl_MULT, ctrl_DIV, md_busy, md_timeout;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clock = ~clock;

  hazard_stall_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .inst_out_fd  (inst_out_fd),
    .DX_inst      (DX_inst),
    .branch_taken (branch_taken),
    .multdiv_ready(multdiv_ready),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .fd_flush     (fd_flush),
    .dx_nop       (dx_nop),
    .xm_nop       (xm_nop),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_busy      (md_busy),
    .md_timeout   (md_timeout)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  // {pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop, ctrl_MULT, ctrl_DIV, md_busy, md_timeout}
  logic [9:0] outs;
  assign outs = {pc_en, fd_en, dx_en, fd_flush, dx_nop, xm_nop, ctrl_MULT, ctrl_DIV, md_busy,
                 md_timeout};

  localparam logic [9:0] PRun    = 10'b111_000_00_00;
  localparam logic [9:0] PRunTo  = 10'b111_000_00_01;
  localparam logic [9:0] PLdUse  = 10'b001_010_00_00;
  localparam logic [9:0] PFlush  = 10'b111_110_00_00;
  localparam logic [9:0] PMStart = 10'b000_001_10_00;
  localparam logic [9:0] PDStart = 10'b000_001_01_00;
  localparam logic [9:0] PWait   = 10'b000_001_00_10;

  localparam logic [31:0] Nop = 32'h0;

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, aluOp);
    return {5'b00000, rd, rs, rt, 5'b00000, aluOp, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs);
    return {op, rd, rs, 17'd0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] exp);
    #1;
    vectors++;
    assert (outs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    inst_out_fd   = Nop;
    DX_inst       = Nop;
    branch_taken  = 1'b0;
    multdiv_ready = 1'b0;
    check("reset", PRun);
    tick();
    reset = 1'b0;
    tick();

    // lw r5 ; add r3,r5,r2 -> one bubble
    DX_inst = itype(5'b01000, 5'd5, 5'd1); inst_out_fd = rtype(5'd3, 5'd5, 5'd2, 5'd0);
    check("lu_rs", PLdUse);
    tick();
    DX_inst = Nop;
    check("lu_bubble_clears", PRun);
    tick();

    DX_inst = itype(5'b01000, 5'd0, 5'd1); inst_out_fd = rtype(5'd3, 5'd0, 5'd0, 5'd0);
    check("lu_r0", PRun);
    DX_inst = itype(5'b01000, 5'd7, 5'd1); inst_out_fd = itype(5'b00111, 5'd7, 5'd2);
    check("lu_sw_data", PRun);
    inst_out_fd = itype(5'b00111, 5'd1, 5'd7);
    check("lu_sw_base", PLdUse);
    inst_out_fd = itype(5'b00010, 5'd7, 5'd3);
    check("lu_bne_rd", PLdUse);
    inst_out_fd = itype(5'b00101, 5'd7, 5'd3);
    check("lu_addi_rd_only", PRun);
    DX_inst = itype(5'b01000, 5'd6, 5'd1); inst_out_fd = rtype(5'd1, 5'd2, 5'd6, 5'd0);
    check("lu_rt", PLdUse);

    branch_taken = 1'b1;
    check("flush_over_lu", PFlush);
    DX_inst = Nop; inst_out_fd = Nop;
    check("flush_alone", PFlush);
    branch_taken = 1'b0;
    tick();

    // mult with a simultaneous (ignored) ready, then 16 frozen cycles, ready on the 17th
    DX_inst = rtype(5'd4, 5'd2, 5'd3, 5'b00110); multdiv_ready = 1'b1;
    check("mult_start", PMStart);
    tick();
    multdiv_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      branch_taken = (i == 3);
      check($sformatf("mult_wait%0d", i), PWait);
      tick();
    end
    branch_taken  = 1'b0;
    multdiv_ready = 1'b1;
    check("mult_release", PRun);
    tick();
    multdiv_ready = 1'b0; DX_inst = Nop;
    check("mult_back_run", PRun);
    tick();

    // div with no ready: 40th wait cycle releases, flag visible afterwards
    DX_inst = rtype(5'd4, 5'd2, 5'd3, 5'b00111);
    check("div_start", PDStart);
    tick();
    for (int i = 0; i < 39; i++) begin
      check($sformatf("div_wait%0d", i), PWait);
      tick();
    end
    check("div_timeout_release", PRun);
    tick();
    DX_inst = Nop;
    check("timeout_flag", PRunTo);
    tick();
    check("timeout_sticky", PRunTo);
    tick();

    // reset during the 5th wait cycle
    DX_inst = rtype(5'd4, 5'd2, 5'd3, 5'b00111);
    check("div2_start_flagged", PDStart | 10'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("div2_wait%0d", i), PWait | 10'b1);
      tick();
    end
    reset = 1'b1;
    check("reset_mid_wait", PRun);
    DX_inst = Nop;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_reset%0d", i), PRun);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller: the stall/flush side of the same hazard interface whose forwarding side feeds the ALU/branch bypass muxes.
- Handles the hazards forwarding cannot cover:
  - load-use: inserts one bubble;
  - multi-cycle mult/div: freezes the front end until the multdiv unit reports ready;
  - taken branch/jump: squashes the wrong-path instructions.
- Sits between the FD/DX latches, the PC register and the multdiv unit in the 5-stage core.

Parameters:
- MD_TIMEOUT, 40, watchdog limit in cycles for an outstanding mult/div before forced release.
- CNT_W, 6, width of the watchdog counter; must hold MD_TIMEOUT.

Ports:
- clock  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inst_out_fd  input  32  instruction in the FD latch.
- DX_inst  input  32  instruction in the DX latch.
- branch_taken  input  1  DX-stage branch/jump resolved taken this cycle.
- multdiv_ready  input  1  multdiv result valid, single-cycle pulse.
- pc_en  output  1  PC register write enable.
- fd_en  output  1  FD latch write enable.
- dx_en  output  1  DX latch write enable.
- fd_flush  output  1  load NOP into FD.
- dx_nop  output  1  load NOP into DX.
- xm_nop  output  1  load NOP into XM.
- ctrl_MULT  output  1  mult start pulse to multdiv.
- ctrl_DIV  output  1  div start pulse to multdiv.
- md_busy  output  1  high while a mult/div is outstanding.
- md_timeout  output  1  sticky watchdog error flag.

Behaviour:
- Opcode is [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- Opcode values: ALU 00000, addi 00101, lw 01000, sw 00111, bne 00010, blt 00110, jr 00100. mult = ALU/00110, div = ALU/00111.
- Reset (async, immediate): state=RUN, counter=0. Outputs: pc_en/fd_en/dx_en=1, fd_flush/dx_nop/xm_nop=0, ctrl_MULT/ctrl_DIV=0, md_busy=0, md_timeout=0.
- States: RUN, MD_WAIT.
- Load-use hazard (combinational, RUN only):
  - Condition: DX op==lw, DX rd!=0, and DX rd matches any of:
    - FD rs, when FD op is ALU, addi, lw or sw;
    - FD rt, when FD op is ALU;
    - FD rd, when FD op is bne, blt or jr.
  - Exclusion: FD sw whose only match is its rd. No stall; the memory-data bypass covers it.
  - Action for that cycle: pc_en=0, fd_en=0, dx_nop=1. Exactly one bubble; the next cycle DX holds the NOP, so the condition clears.
- Branch flush (RUN): branch_taken=1 gives fd_flush=1 and dx_nop=1, with pc_en/fd_en=1. The flush beats load-use: when both are active, the flush outputs win and pc_en stays 1.
- Mult/div start (RUN, DX is mult or div):
  - ctrl_MULT or ctrl_DIV=1 for exactly that cycle.
  - pc_en/fd_en/dx_en=0, xm_nop=1.
  - Next state MD_WAIT; counter cleared to 0.
- MD_WAIT:
  - md_busy=1; pc_en/fd_en/dx_en=0; xm_nop=1; no start pulses.
  - Counter increments each cycle.
  - multdiv_ready=1: that cycle all enables=1, xm_nop=0 (the result enters XM), md_busy=0, next state RUN.
  - Counter reaching MD_TIMEOUT without ready: set md_timeout (held until reset), release the same way as ready, return to RUN.
  - branch_taken and load-use are ignored in MD_WAIT: DX is frozen on the mult/div, so neither can be legal.
- Ready in the same cycle as the start pulse is ignored.
- A back-to-back mult/div in FD is started when it reaches DX after the release. No overlap.
- Reset asserted mid-MD_WAIT: return to RUN and drop md_busy immediately. No start pulse is re-issued.

Optional Feature:
- Macro: HAZARD_STALL_STATS_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[15:0]. Both clear on reset.
  - stall_cycles increments every cycle pc_en==0.
  - flush_count increments every cycle fd_flush==1.
  - Both saturate, never wrap.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- DX=lw r5; FD=add r3,r5,r2 -> one cycle pc_en=0, fd_en=0, dx_nop=1; next cycle all enables=1 and dx_nop=0.
- DX=lw r0; FD=add r3,r0,r0 -> no stall.
- DX=lw r7; FD=sw r7,0(r2) -> no stall.
- DX=lw r7; FD=sw r1,0(r7) -> one-cycle stall.
- DX=mult r4,r2,r3 -> ctrl_MULT=1 for 1 cycle; md_busy=1. Then multdiv_ready pulsed 17 cycles later -> enables frozen for those 17 cycles, released on the ready cycle, state back to RUN.
- DX=div with no ready, MD_TIMEOUT=40 -> md_timeout=1 after 40 MD_WAIT cycles; pipeline released; flag still 1 until reset.
- branch_taken=1 while the load-use condition is also true -> fd_flush=1, dx_nop=1, pc_en=1.
- reset pulsed mid-MD_WAIT (cycle 5) -> md_busy=0 and enables=1 immediately; no ctrl_DIV re-pulse after reset release.
